// File: rtl/chimp_pkg.sv
// Shared types and constants for the chimp-test board generator.
package chimp_pkg;

    // Build sequencer states.
    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCheck,
        StDone
    } chimp_state_e;

    localparam int unsigned GRID_CELLS_DEF = 12;
    // Width of a cell index, a number index and a level value.
    localparam int unsigned CELL_W = 4;

endpackage

// File: rtl/chimp_board_gen_lowest_free_cell.sv
// Priority encoder: index of the lowest clear bit of the occupancy mask.
module lowest_free_cell
    import chimp_pkg::*;
#(
    parameter int unsigned CELLS = GRID_CELLS_DEF
) (
    input  logic [CELLS-1:0]  mask,
    output logic [CELL_W-1:0] idx,
    output logic              valid
);

    // Scan from the top down so the lowest free cell wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = CELLS - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                idx   = CELL_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chimp_board_gen.sv
// Builds a collision-free chimp-test board from bounded random samples.
module chimp_board_gen
    import chimp_pkg::*;
#(
    parameter int unsigned GRID_CELLS = GRID_CELLS_DEF,
    parameter int unsigned SAMPLE_GAP = 14,
    parameter int unsigned MAX_REJECT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CELL_W-1:0]     level,
    input  logic [CELL_W-1:0]     rnd,
    output logic [CELL_W-1:0]     bound,
    output logic                  busy,
    output logic                  done,
    output logic [CELL_W-1:0]     placed_count,
    output logic [GRID_CELLS-1:0] cell_mask,
    input  logic [CELL_W-1:0]     rd_idx,
    output logic [CELL_W-1:0]     rd_cell
);

    localparam int unsigned GAP_W = $clog2(SAMPLE_GAP);
    localparam int unsigned REJ_W = $clog2(MAX_REJECT + 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SAMPLE_GAP - 1);
    localparam logic [REJ_W-1:0]  REJ_LIMIT = REJ_W'(MAX_REJECT);
    localparam logic [CELL_W-1:0] CELLS_C   = CELL_W'(GRID_CELLS);

    chimp_state_e      state_q;
    logic [CELL_W-1:0] n_q;
    logic [CELL_W-1:0] cand_q;
    logic [GAP_W-1:0]  gap_q;
    logic [REJ_W-1:0]  rej_q;
    logic [CELL_W-1:0] cell_tab_q [GRID_CELLS];

    logic [CELL_W-1:0]      nl;
    logic [2**CELL_W-1:0]   mask_pad;
    logic                   reject;
    logic [REJ_W-1:0]       rej_next;
    logic                   force_place;
    logic [CELL_W-1:0]      place_cell;
    logic [CELL_W-1:0]      placed_next;
    logic [CELL_W-1:0]      free_idx;
    logic                   free_valid;

    assign bound = CELLS_C;

    lowest_free_cell #(
        .CELLS (GRID_CELLS)
    ) u_free (
        .mask  (cell_mask),
        .idx   (free_idx),
        .valid (free_valid)
    );

    // Candidate evaluation for the CHECK state; the mask is padded so any 4-bit cand indexes it.
    always_comb begin
        nl          = (level > CELLS_C) ? CELLS_C : level;
        mask_pad    = (2**CELL_W)'(cell_mask);
        reject      = (cand_q >= CELLS_C) || mask_pad[cand_q];
        rej_next    = rej_q + REJ_W'(1);
        force_place = reject && (rej_next == REJ_LIMIT) && free_valid;
        place_cell  = reject ? free_idx : cand_q;
        placed_next = placed_count + CELL_W'(1);
    end

    // Build sequencer with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            n_q          <= '0;
            cand_q       <= '0;
            gap_q        <= '0;
            rej_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            placed_count <= '0;
            cell_mask    <= '0;
            for (int i = 0; i < GRID_CELLS; i++) cell_tab_q[i] <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        n_q          <= nl;
                        cell_mask    <= '0;
                        placed_count <= '0;
                        rej_q        <= '0;
                        gap_q        <= '0;
                        busy         <= 1'b1;
                        for (int i = 0; i < GRID_CELLS; i++) cell_tab_q[i] <= '0;
                        if (nl == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (gap_q == GAP_LAST) begin
                        cand_q  <= rnd;
                        gap_q   <= '0;
                        state_q <= StCheck;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                StCheck: begin
                    if (reject && !force_place) begin
                        rej_q   <= rej_next;
                        state_q <= StWait;
                    end else begin
                        for (int i = 0; i < GRID_CELLS; i++) begin
                            if (placed_count == CELL_W'(i)) cell_tab_q[i] <= place_cell;
                        end
                        cell_mask    <= cell_mask | (GRID_CELLS'(1) << place_cell);
                        placed_count <= placed_next;
                        rej_q        <= '0;
                        if (placed_next == n_q) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Table read port; indices at or beyond placed_count read as zero.
    always_comb begin
        rd_cell = '0;
        for (int i = 0; i < GRID_CELLS; i++) begin
            if (rd_idx == CELL_W'(i) && rd_idx < placed_count) rd_cell = cell_tab_q[i];
        end
    end

endmodule

// File: tb/tb_chimp_board_gen.sv
// Self-checking bench for chimp_board_gen against a board-level reference model.
module tb_chimp_board_gen;

    localparam int CELLS = 12;
    localparam int GAP   = 14;
    localparam int MAXR  = 8;
    localparam int ATT   = GAP + 1;
    localparam int LIM   = CELLS * MAXR * ATT + 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  level = '0;
    logic [3:0]  rnd = '0;
    logic [3:0]  bound;
    logic        busy;
    logic        done;
    logic [3:0]  placed_count;
    logic [11:0] cell_mask;
    logic [3:0]  rd_idx = '0;
    logic [3:0]  rd_cell;

    int checks = 0;
    int errors = 0;

    logic [3:0]  stream [128];
    int          exp_tab [16];
    logic [11:0] exp_mask;
    int          exp_cnt;
    int          exp_att;

    chimp_board_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .level        (level),
        .rnd          (rnd),
        .bound        (bound),
        .busy         (busy),
        .done         (done),
        .placed_count (placed_count),
        .cell_mask    (cell_mask),
        .rd_idx       (rd_idx),
        .rd_cell      (rd_cell)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 128; i++) stream[i] = 4'($urandom_range(0, 15));
    endtask

    // Board-level model: walk the sample stream applying the placement rules.
    task automatic model(input int lvl);
        bit occ [CELLS];
        int n, rej, c, f;
        n = (lvl > CELLS) ? CELLS : lvl;
        for (int i = 0; i < CELLS; i++) occ[i] = 0;
        for (int i = 0; i < 16; i++) exp_tab[i] = 0;
        exp_cnt = 0;
        exp_att = 0;
        rej = 0;
        while (exp_cnt < n) begin
            c = stream[exp_att];
            exp_att++;
            if (c >= CELLS || occ[c]) begin
                rej++;
                if (rej == MAXR) begin
                    f = 0;
                    while (occ[f]) f++;
                    occ[f] = 1;
                    exp_tab[exp_cnt] = f;
                    exp_cnt++;
                    rej = 0;
                end
            end else begin
                occ[c] = 1;
                exp_tab[exp_cnt] = c;
                exp_cnt++;
                rej = 0;
            end
        end
        exp_mask = '0;
        for (int i = 0; i < CELLS; i++) exp_mask[i] = occ[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Start a build, feed one stream entry per attempt window, then check the board.
    task automatic build(input string tag, input logic [3:0] lvl, input int poke);
        int m;
        int got;
        model(int'(lvl));
        @(negedge clk);
        start = 1'b1;
        level = lvl;
        rnd   = stream[0];
        @(negedge clk);
        start = 1'b0;
        m   = 0;
        got = -1;
        while (m <= LIM) begin
            if (done) begin
                got = m;
                break;
            end
            rnd   = stream[(m / ATT) % 128];
            start = (m == poke);
            level = 4'd1;
            @(negedge clk);
            m++;
        end
        start = 1'b0;
        if (got < 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_latency"}, 32'(got + 1), 32'(exp_att * ATT + 1));
            check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
            check({tag, "_count"}, 32'(placed_count), 32'(exp_cnt));
            check({tag, "_mask"}, 32'(cell_mask), 32'(exp_mask));
            for (int i = 0; i < 16; i++) begin
                rd_idx = 4'(i);
                #1;
                check({tag, "_rd_cell"}, 32'(rd_cell), 32'(exp_tab[i]));
            end
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
            check({tag, "_busy_after"}, 32'(busy), 32'd0);
            check({tag, "_mask_hold"}, 32'(cell_mask), 32'(exp_mask));
        end
    endtask

    initial begin
        do_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(placed_count), 32'd0);
        check("rst_mask", 32'(cell_mask), 32'd0);
        check("bound", 32'(bound), 32'd12);
        rd_idx = 4'd0;
        #1;
        check("rst_rd_cell", 32'(rd_cell), 32'd0);

        fill_random();
        stream[0] = 4'd5; stream[1] = 4'd2; stream[2] = 4'd9;
        build("lvl3", 4'd3, -1);

        fill_random();
        stream[0] = 4'd4; stream[1] = 4'd4; stream[2] = 4'd7;
        build("dup", 4'd2, -1);

        for (int i = 0; i < 128; i++) stream[i] = 4'd3;
        build("stuck3", 4'd2, -1);
        check("stuck3_mask_literal", 32'(cell_mask), 32'h009);

        fill_random();
        stream[0] = 4'd13; stream[1] = 4'd0;
        build("oob", 4'd1, -1);

        build("lvl0", 4'd0, -1);

        fill_random();
        build("lvl15", 4'd15, -1);
        check("lvl15_full", 32'(cell_mask), 32'hFFF);

        fill_random();
        stream[0] = 4'd6; stream[1] = 4'd1; stream[2] = 4'd11;
        build("start_busy", 4'd3, 20);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            build("rand", 4'($urandom_range(0, 15)), -1);
        end

        // Reset during WAIT after the first placement abandons the build.
        fill_random();
        stream[0] = 4'd5;
        @(negedge clk);
        start = 1'b1;
        level = 4'd3;
        rnd   = stream[0];
        @(negedge clk);
        start = 1'b0;
        for (int m = 0; m < 20; m++) begin
            rnd = stream[(m / ATT) % 128];
            @(negedge clk);
        end
        check("mid_count_pre", 32'(placed_count), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_mask", 32'(cell_mask), 32'd0);
        check("mid_count", 32'(placed_count), 32'd0);
        begin
            int seen = 0;
            for (int m = 0; m < 60; m++) begin
                if (done) seen = 1;
                @(negedge clk);
            end
            check("mid_no_done", 32'(seen), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
